// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Iterative RV32M multiply/divide sequencer for the EX stage.
//            Shift-add multiplier and restoring divider run on a shared
//            2*XLEN accumulator for ITER cycles. The unit stalls the
//            pipeline while it works and pulses done_o with the result.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(ITER);
   localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PREP  = 3'd1,
      S_CALC  = 3'd2,
      S_FIXUP = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [XLEN-1:0]     a_q, a_d;
   logic [XLEN-1:0]     b_q, b_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;     // multiplicand or divisor magnitude
   logic [2*XLEN-1:0]   acc_q, acc_d;       // {hi, lo}: product or {rem, quot}
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                sign_q, sign_d;     // sign of the selected result
   logic [XLEN-1:0]     result_q, result_d;

   // Operand signedness and magnitudes, evaluated from the latched operands
   logic                w_signed_a, w_signed_b, w_sa, w_sb;
   logic [XLEN-1:0]     w_a_mag, w_b_mag;
   logic                w_div_zero, w_div_ovf;

   assign w_signed_a = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                       (op_q == OP_DIV)  || (op_q == OP_REM);
   assign w_signed_b = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
   assign w_sa       = w_signed_a & a_q[XLEN-1];
   assign w_sb       = w_signed_b & b_q[XLEN-1];
   assign w_a_mag    = w_sa ? -a_q : a_q;
   assign w_b_mag    = w_sb ? -b_q : b_q;
   assign w_div_zero = (b_q == '0);
   // Signed overflow only exists for DIV/REM (op bit 0 clear)
   assign w_div_ovf  = !op_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);

   // Multiply step: add multiplicand into the high half when the current
   // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
   logic [XLEN:0]       w_mul_sum;
   logic [2*XLEN-1:0]   w_mul_next;
   assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                       {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
   assign w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};

   // Divide step: shift {rem,quot} left, trial-subtract the divisor from the
   // shifted remainder (XLEN+1 bits wide), keep it when non-negative.
   logic [XLEN:0]       w_rem_sh;
   logic [XLEN+1:0]     w_trial;
   logic [2*XLEN-1:0]   w_div_next;
   assign w_rem_sh   = acc_q[2*XLEN-1:XLEN-1];
   assign w_trial    = {1'b0, w_rem_sh} - {2'b00, opnd_q};
   assign w_div_next = w_trial[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {w_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

   // Sign correction and result selection for the FIXUP cycle
   logic [2*XLEN-1:0]   w_prod_fix;
   logic [XLEN-1:0]     w_quot_fix, w_rem_fix, w_fix_sel;
   assign w_prod_fix = sign_q ? -acc_q : acc_q;
   assign w_quot_fix = sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign w_rem_fix  = sign_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

   // Pick the architectural result for the latched opcode
   always_comb begin
      w_fix_sel = w_prod_fix[XLEN-1:0];
      case (op_q)
         OP_MUL:                       w_fix_sel = w_prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_fix_sel = w_prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              w_fix_sel = w_quot_fix;
         OP_REM, OP_REMU:              w_fix_sel = w_rem_fix;
         default:                      w_fix_sel = w_prod_fix[XLEN-1:0];
      endcase
   end

   assign busy_o   = (state_q != S_IDLE);
   assign result_o = result_q;

   // Next-state, datapath update and handshake outputs
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sign_d   = sign_q;
      result_d = result_q;
      stall_o  = 1'b0;
      done_o   = 1'b0;

      case (state_q)
         S_IDLE: begin
            stall_o = start_i;
            if (start_i && !flush_i) begin
               op_d    = op_i;
               a_d     = rs1_i;
               b_d     = rs2_i;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            stall_o = 1'b1;
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               cnt_d  = '0;
               // Remainder follows the dividend; everything else is sA ^ sB
               sign_d = (op_q[2] && op_q[1]) ? w_sa : (w_sa ^ w_sb);
               // Multiplier rides in the low half; dividend for division
               acc_d  = op_q[2] ? {{XLEN{1'b0}}, w_a_mag} : {{XLEN{1'b0}}, w_b_mag};
               opnd_d = op_q[2] ? w_b_mag : w_a_mag;
               if (op_q[2] && w_div_zero) begin
                  result_d = op_q[1] ? a_q : {XLEN{1'b1}};
                  state_d  = S_DONE;
               end else if (op_q[2] && w_div_ovf) begin
                  result_d = op_q[1] ? {XLEN{1'b0}} : a_q;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            stall_o = 1'b1;
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               acc_d = op_q[2] ? w_div_next : w_mul_next;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = S_FIXUP;
               end
            end
         end
         S_FIXUP: begin
            stall_o = 1'b1;
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               result_d = w_fix_sel;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            done_o  = !flush_i;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sign_q   <= sign_d;
         result_q <= result_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Self-checking bench for muldiv_seq. Expected results and
//            latencies are queued when an operation is launched and compared
//            when done_o is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [2:0]  op_i = '0;
   logic [31:0] rs1_i = '0;
   logic [31:0] rs2_i = '0;
   logic        flush_i = 1'b0;
   logic        busy_o, stall_o, done_o;
   logic [31:0] result_o;

   muldiv_seq #(.XLEN(32), .ITER(32)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (start_i),
      .op_i     (op_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .flush_i  (flush_i),
      .busy_o   (busy_o),
      .stall_o  (stall_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_res_q[$];
   int          exp_lat_q[$];
   logic [31:0] last_res = '0;
   bit          hold_g = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference RV32M result
   function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = '0;
      r  = '0;
      case (op)
         3'd0: begin p = sa * sb; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else begin p = sa / sb; r = p[31:0]; end
         end
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
      if (op[2] && (b == 0)) return 2;
      if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 35;
   endfunction

   // Drive a request at a negedge, queue its expectation, pass the accept edge
   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input int el, input bit hold);
      op_i    = op;
      rs1_i   = a;
      rs2_i   = b;
      start_i = 1'b1;
      hold_g  = hold;
      exp_res_q.push_back(er);
      exp_lat_q.push_back(el);
      @(posedge clk_i);
   endtask

   // Wait (bounded) for done_o, then pop and compare; returns at DONE negedge
   task automatic collect(input string tag);
      int          n;
      int          bad;
      logic [31:0] er;
      int          el;
      n   = 0;
      bad = 0;
      while (n < 100) begin
         @(negedge clk_i);
         n++;
         if (n == 1) begin
            if (!hold_g) start_i = 1'b0;
            op_i  = 3'($urandom);
            rs1_i = $urandom;
            rs2_i = $urandom;
         end
         if (hold_g && n == 30) start_i = 1'b0;
         if (done_o === 1'b1) break;
         if (stall_o !== 1'b1 || busy_o !== 1'b1) bad++;
      end
      start_i = 1'b0;
      er = exp_res_q.pop_front();
      el = exp_lat_q.pop_front();
      chk({tag, "/latency"}, n, el);
      chk({tag, "/result"}, result_o, er);
      chk({tag, "/stall_in_done"}, {31'b0, stall_o}, 32'd0);
      chk({tag, "/stall_busy_run"}, bad, 32'd0);
      last_res = er;
   endtask

   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input int el);
      launch(op, a, b, er, el, 1'b0);
      collect(tag);
      @(negedge clk_i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          pulses;

      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("reset/busy", {31'b0, busy_o}, 32'd0);
      chk("reset/done", {31'b0, done_o}, 32'd0);
      chk("reset/stall", {31'b0, stall_o}, 32'd0);
      chk("reset/result", result_o, 32'd0);

      // Combinational stall request in IDLE
      start_i = 1'b1;
      #1 chk("idle/stall_eq_start", {31'b0, stall_o}, 32'd1);
      start_i = 1'b0;
      #1 chk("idle/stall_low", {31'b0, stall_o}, 32'd0);
      @(negedge clk_i);

      do_op("mul_7_m3",   3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
      do_op("mulh",       3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 35);
      do_op("mulhsu",     3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35);
      do_op("mulhu",      3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 35);
      do_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35);
      do_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35);
      do_op("divu_100_7", 3'd5, 32'd100,       32'd7,         32'd14,        35);
      do_op("remu_100_7", 3'd7, 32'd100,       32'd7,         32'd2,         35);
      do_op("div_5_0",    3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 2);
      do_op("remu_5_0",   3'd7, 32'd5,         32'd0,         32'd5,         2);
      do_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);

      // REM overflow, then flush during DONE must squash the pulse
      launch(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2, 1'b0);
      collect("rem_ovf");
      flush_i = 1'b1;
      #1 chk("flush_in_done/done", {31'b0, done_o}, 32'd0);
      @(negedge clk_i);
      flush_i = 1'b0;

      // Back-to-back: a start during DONE is ignored, accepted next cycle
      launch(3'd5, 32'd1000, 32'd10, 32'd100, 35, 1'b0);
      collect("b2b_first");
      op_i    = 3'd0;
      rs1_i   = 32'd12;
      rs2_i   = 32'd11;
      start_i = 1'b1;
      @(negedge clk_i);
      chk("b2b/ignored_in_done", {31'b0, busy_o}, 32'd0);
      chk("b2b/stall_idle", {31'b0, stall_o}, 32'd1);
      launch(3'd0, 32'd12, 32'd11, 32'd132, 35, 1'b0);
      collect("b2b_second");
      @(negedge clk_i);

      // Flush at CALC cycle 10: back to IDLE, no pulse, result unchanged
      op_i    = 3'd0;
      rs1_i   = 32'd3;
      rs2_i   = 32'd5;
      start_i = 1'b1;
      @(posedge clk_i);
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk_i);
         start_i = 1'b0;
      end
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      chk("flush_calc/busy", {31'b0, busy_o}, 32'd0);
      chk("flush_calc/result_kept", result_o, last_res);
      pulses = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk_i);
         if (done_o === 1'b1) pulses++;
      end
      chk("flush_calc/no_done", pulses, 32'd0);
      do_op("after_flush", 3'd5, 32'd81, 32'd9, 32'd9, 35);

      // Flush and start together in IDLE: nothing accepted
      start_i = 1'b1;
      flush_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      flush_i = 1'b0;
      chk("flush_start_idle/busy", {31'b0, busy_o}, 32'd0);

      // start_i held high while busy, with scrambled operands
      launch(3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 35, 1'b1);
      collect("hold_start");
      @(negedge clk_i);

      // Reset mid-CALC
      op_i    = 3'd4;
      rs1_i   = 32'd1234;
      rs2_i   = 32'd5;
      start_i = 1'b1;
      @(posedge clk_i);
      for (int n = 1; n <= 15; n++) begin
         @(negedge clk_i);
         start_i = 1'b0;
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("rst_mid/busy", {31'b0, busy_o}, 32'd0);
      chk("rst_mid/stall", {31'b0, stall_o}, 32'd0);
      chk("rst_mid/result", result_o, 32'd0);
      do_op("after_rst", 3'd7, 32'd1234, 32'd5, 32'd4, 35);

      // Random operations against the reference model
      for (int i = 0; i < 24; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = (i % 6 == 5) ? 32'($urandom_range(0, 2)) : $urandom;
         if (i % 4 == 3) ra = ra >> $urandom_range(0, 31);
         do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb,
               ref_md(rop, ra, rb), ref_lat(rop, ra, rb));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer placed beside the single-cycle ALU in the execution stage.
- Accepts one M-extension operation from EX and runs a shift-add multiplier or restoring divider for 32 iterations.
- Holds the pipeline through a stall output, then presents the 32-bit result for the EX result mux.
- Owns the stall source for multi-cycle arithmetic so the ALU stays single-cycle.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations in CALC; must equal XLEN.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request; sampled only in IDLE.
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  in  XLEN  operand A (dividend/multiplicand), post-forwarding.
- rs2_i  in  XLEN  operand B (divisor/multiplier), post-forwarding.
- flush_i  in  1  abort the current operation (branch or trap flush).
- busy_o  out  1  high in any state other than IDLE.
- stall_o  out  1  pipeline hold request to the hazard logic.
- done_o  out  1  one-cycle pulse; result_o valid in this cycle.
- result_o  out  XLEN  final result; held until the next accepted start.

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE, busy_o=0, done_o=0, result_o=0, all internal registers cleared. Reset overrides flush_i and start_i.
- States: IDLE, PREP, CALC, FIXUP, DONE.
- IDLE:
  - start_i=1 latches op_i, rs1_i and rs2_i, then moves to PREP.
  - stall_o = start_i, combinational in IDLE.
- PREP (1 cycle):
  - Takes magnitudes of signed operands: MULH and DIV/REM sign both operands; MULHSU signs rs1 only.
  - Records the result sign: product sign = sA xor sB; quotient sign = sA xor sB; remainder sign = sA.
  - Clears the accumulator and iteration counter.
  - Special cases go directly to DONE with the result loaded:
    - rs2 = 0, DIV/DIVU: result all ones (0xFFFFFFFF).
    - rs2 = 0, REM/REMU: result = rs1.
    - DIV with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: result 0x80000000.
    - REM with the same operands: result 0.
  - Otherwise moves to CALC.
- CALC (exactly ITER cycles, counter 0..31):
  - Multiply: 64-bit shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring; shift {rem,quot} left 1, trial-subtract the divisor, set the quotient bit when the trial result is non-negative.
  - At counter = 31, moves to FIXUP.
- FIXUP (1 cycle):
  - Applies two's-complement negation when the recorded sign is 1.
  - Selects product[31:0] for MUL and product[63:32] for MULH/MULHSU/MULHU.
  - Selects the quotient for DIV/DIVU and the remainder for REM/REMU.
  - Registers the value into result_o and moves to DONE.
- DONE (1 cycle): done_o=1, stall_o=0, then moves to IDLE.
- stall_o:
  - = 1 in PREP, CALC and FIXUP.
  - = start_i in IDLE.
  - = 0 in DONE.
  - The EX stage therefore advances on the edge that ends DONE.
- Latency: with the start edge at T0, normal operations assert done_o during cycle T0+35 (PREP 1, CALC 32, FIXUP 1). Special cases assert done_o during T0+2.
- Back-to-back: a start_i high during DONE is ignored. A new operation is accepted only in IDLE, so the earliest re-accept is the cycle after DONE.
- start_i in any non-IDLE state is ignored; latched operands are not disturbed.
- flush_i=1 in PREP, CALC, FIXUP or DONE:
  - Next state is IDLE; done_o is forced to 0 in that cycle; result_o is not updated.
  - flush_i and start_i together in IDLE: flush wins and nothing is accepted.
- Operands are latched at acceptance, so later changes on rs1_i/rs2_i have no effect on the running operation.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD) -> done_o at T0+35, result_o=0xFFFFFFEB; stall_o high T0..T0+34, low at T0+35.
- MULH/MULHSU/MULHU with rs1=0x80000000, rs2=0xFFFFFFFF:
  - MULH -> 0x00000000.
  - MULHSU -> 0x80000000.
  - MULHU -> 0x7FFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> done_o at T0+2, result 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM of the same operands -> 0.
- flush_i at CALC cycle 10 -> IDLE next cycle, no done_o pulse, result_o keeps its previous value; a new start is then accepted with correct latency.
- rst_i asserted mid-CALC -> next cycle busy_o=0, stall_o=0, result_o=0; start_i held high during busy is ignored with operands unchanged.
